// File: rtl/product_display_pkg.sv
// Shared types, segment constants and helpers for the product readout display.
package product_display_pkg;

    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned BIN_W      = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StRead = 3'd1;
    localparam state_t StCapt = 3'd2;
    localparam state_t StConv = 3'd3;
    localparam state_t StLoad = 3'd4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one iteration per clock.
module bin2bcd_seq
    import product_display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             valid
);

    localparam int unsigned SrW = BIN_W + BCD_W;

    logic [SrW-1:0] sr_q;
    logic [SrW-1:0] sr_adj;
    logic [2:0]     cnt_q;
    logic           run_q;

    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            sr_q  <= {{BCD_W{1'b0}}, bin};
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            sr_q  <= {sr_adj[SrW-2:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                run_q <= 1'b0;
            end
        end
    end

    // High during the final iteration; bcd holds the result from the next cycle on.
    assign valid = run_q && (cnt_q == 3'd7);
    assign bcd   = sr_q[SrW-1:BIN_W];

endmodule

// File: rtl/product_display.sv
// Reads one product RAM word, converts it to BCD and scans it onto a 4-digit 7-seg display.
module product_display
    import product_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       sel_addr,
    input  logic [BIN_W-1:0] rd_data,
    output logic [2:0]       rd_addr,
    output logic             busy,
    output logic             done,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int unsigned PreW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t           state_q, state_d;
    logic [2:0]       rd_addr_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       digit_q [4];
    logic [3:0]       digit_d [4];
    logic [BCD_W-1:0] bcd;
    logic             conv_last;
    logic             accept;

    logic [PreW-1:0]  pre_q;
    logic             tick;
    logic [1:0]       idx_q;
    logic [1:0]       show_q;
    logic [1:0]       seg_sel;
    logic             scan_on_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q, seg_d;

    assign accept = (state_q == StIdle) && start;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == StCapt),
        .bin   (rd_data),
        .bcd   (bcd),
        .valid (conv_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  state_d = StCapt;
            StCapt:  state_d = StConv;
            StConv:  if (conv_last) state_d = StLoad;
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_d[i] = digit_q[i];
        end
        if (state_q == StLoad) begin
            digit_d[3] = {1'b0, rd_addr_q};
            digit_d[2] = bcd[11:8];
            digit_d[1] = bcd[7:4];
            digit_d[0] = bcd[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StLoad);
            if (accept) begin
                rd_addr_q <= sel_addr;
                busy_q    <= 1'b1;
            end else if (state_q == StLoad) begin
                busy_q <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    // Scan: an reflects idx_q as it was at the tick; show_q remembers which digit is lit.
    assign tick    = (pre_q == PreW'(REFRESH_DIV - 1));
    assign seg_sel = tick ? idx_q : show_q;

    // Use next-state digits so a fresh load shows on seg in the same cycle digits update.
    always_comb begin
        seg_d = SEG_BLANK;
        if (tick || scan_on_q) begin
            seg_d = seg_encode(digit_d[seg_sel]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            idx_q     <= '0;
            show_q    <= '0;
            scan_on_q <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            seg_q <= seg_d;
            if (tick) begin
                pre_q     <= '0;
                idx_q     <= idx_q + 2'd1;
                show_q    <= idx_q;
                scan_on_q <= 1'b1;
                an_q      <= ~(4'b0001 << idx_q);
            end else begin
                pre_q <= pre_q + PreW'(1);
            end
        end
    end

    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
